// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined fadd among NREQ requesters.
// Results are routed back to the issuing requester via a tag pipe matched to the adder latency.
module fadd_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 stall,
  output logic [31:0]          fadd_x1,
  output logic [31:0]          fadd_x2,
  input  logic [31:0]          fadd_y,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_y,
  output logic                 idle
);

  localparam int IW = $clog2(NREQ);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0]   r_last;
  logic [31:0]     r_x1;
  logic [31:0]     r_x2;
  tag_t [LAT:0]    r_tag;
  logic [NREQ-1:0] r_resp_valid;
  logic [31:0]     r_resp_y;

  logic            w_xfer;
  logic [IW-1:0]   w_win;
  logic            w_busy;

  // Search starts one past the last winner so every requester is served once per NREQ grants.
  always_comb begin
    logic [IW-1:0] idx;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    w_xfer = 1'b0;
    w_win  = '0;
    idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IW'((int'(r_last) + off) % NREQ);
      if (!w_xfer && req_valid[idx]) begin
        w_xfer = 1'b1;
        w_win  = idx;
      end
    end
    if (stall || !rstn) begin
      w_xfer = 1'b0;
    end
  end

  assign req_ready = w_xfer ? (NREQ'(1) << w_win) : '0;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last       <= IW'(NREQ - 1);
      r_x1         <= '0;
      r_x2         <= '0;
      r_tag        <= '0;
      r_resp_valid <= '0;
      r_resp_y     <= '0;
    end else begin
      if (w_xfer) begin
        r_x1   <= req_x1[32*w_win +: 32];
        r_x2   <= req_x2[32*w_win +: 32];
        r_last <= w_win;
      end
      r_tag[0] <= '{valid: w_xfer, id: w_win};
      for (int i = 1; i <= LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      // The tail tag lines up with fadd_y of the op it describes.
      if (r_tag[LAT].valid) begin
        r_resp_valid <= NREQ'(1) << r_tag[LAT].id;
        r_resp_y     <= fadd_y;
      end else begin
        r_resp_valid <= '0;
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      w_busy = w_busy | r_tag[i].valid;
    end
  end

  assign fadd_x1    = r_x1;
  assign fadd_x2    = r_x2;
  assign resp_valid = r_resp_valid;
  assign resp_y     = r_resp_y;
  assign idle       = !w_busy && (r_resp_valid == '0);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter: directed scenarios plus random traffic against
// a queue-based model of grants and in-order responses; a behavioural fp adder sits on the adder port.
module tb_fadd_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                clk;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_x1;
  logic [32*NREQ-1:0]  req_x2;
  logic [NREQ-1:0]     req_ready;
  logic                stall;
  logic [31:0]         fadd_x1;
  logic [31:0]         fadd_x2;
  logic [31:0]         fadd_y;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_y;
  logic                idle;

  logic [31:0] x1 [NREQ];
  logic [31:0] x2 [NREQ];

  fadd_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_ready(req_ready),
    .stall(stall),
    .fadd_x1(fadd_x1), .fadd_x2(fadd_x2), .fadd_y(fadd_y),
    .resp_valid(resp_valid), .resp_y(resp_y), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_x1 = '0;
    req_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x1[32*i +: 32] = x1[i];
      req_x2[32*i +: 32] = x2[i];
    end
  end

  // Single <-> double conversion for normal numbers and zero; operands are small integers,
  // so every sum is exact.
  function automatic real f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return $bitstoreal({f[31], 63'd0});
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return d2f(f2d(a) + f2d(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    int n;
    n = int'($urandom_range(0, 2000)) - 1000;
    return d2f(real'(n));
  endfunction

  // Behavioural adder: result valid LAT edges after the operands are registered.
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= fp_add(fadd_x1, fadd_x2);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign fadd_y = apipe[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] y;
  } exp_t;

  exp_t        q[$];
  int          m_last = NREQ - 1;
  logic [31:0] m_x1   = '0;
  logic [31:0] m_x2   = '0;

  // Model: pending responses are a FIFO of (due edge, owner, sum); grant is the first
  // valid requester after the last winner.
  task automatic model_check();
    logic [NREQ-1:0] erv;
    logic [NREQ-1:0] eg;
    logic            pulse;
    int              win;
    if (!rstn) begin
      q.delete();
      m_last = NREQ - 1;
      m_x1   = '0;
      m_x2   = '0;
    end
    erv   = '0;
    pulse = 1'b0;
    if (q.size() > 0 && q[0].due == n_edge) begin
      pulse        = 1'b1;
      erv[q[0].id] = 1'b1;
      check("resp_y", resp_y, q[0].y);
      void'(q.pop_front());
    end
    check("resp_valid", 32'(resp_valid), 32'(erv));
    check("idle", 32'(idle), 32'(q.size() == 0 && !pulse));
    check("fadd_x1", fadd_x1, m_x1);
    check("fadd_x2", fadd_x2, m_x2);
    win = -1;
    if (rstn && !stall) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (win < 0 && req_valid[c]) win = c;
      end
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    if (win >= 0) begin
      m_last = win;
      m_x1   = x1[win];
      m_x2   = x2[win];
      q.push_back('{due: n_edge + LAT + 2, id: win, y: fp_add(x1[win], x2[win])});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      x1[i] = rand_fp();
      x2[i] = rand_fp();
    end
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) tick();
  endtask

  initial begin
    rstn      = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      x1[i] = '0;
      x2[i] = '0;
    end
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Single op from requester 1: 1.0 + 2.0
    req_valid = 4'b0010;
    x1[1] = 32'h3F800000;
    x2[1] = 32'h40000000;
    tick();
    drain(7);

    // Contention: all valid for 8 cycles
    req_valid = '1;
    repeat (8) begin rand_ops(); tick(); end
    drain(6);

    // Stall mid-stream
    req_valid = '1;
    repeat (3) begin rand_ops(); tick(); end
    stall = 1'b1;
    repeat (2) begin rand_ops(); tick(); end
    stall = 1'b0;
    repeat (4) begin rand_ops(); tick(); end
    drain(6);

    // Sole requester 0, distinct operands
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      x1[0] = d2f(real'(i + 1));
      x2[0] = d2f(real'(10 * i));
      tick();
    end
    drain(6);

    // Reset mid-flight
    req_valid = '1;
    repeat (3) begin rand_ops(); tick(); end
    drain(2);
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    drain(4);
    req_valid = '1;
    rand_ops();
    tick();
    drain(6);

    // Zero operand passed through bit-exact
    req_valid = 4'b0001;
    x1[0] = 32'h00000000;
    x2[0] = 32'hC0A00000;
    tick();
    drain(6);

    // Random traffic with occasional stalls and resets
    for (int c = 0; c < 1500; c++) begin
      req_valid = NREQ'($urandom);
      stall     = ($urandom_range(0, 7) == 0);
      rstn      = ($urandom_range(0, 199) != 0);
      rand_ops();
      tick();
    end
    rstn  = 1'b1;
    stall = 1'b0;
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
